uart_rx: RTL and testbench

- 8N1 UART receiver for the slurm16 SoC; the receive counterpart of the existing uart_tx path.
- Oversamples the asynchronous rx pin with the system clock and deserialises bytes LSB-first.
- Received bytes go into a show-ahead FIFO that the CPU peripheral bus pops.
- Maintains sticky framing-error and overrun flags.

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled rx line, LSB-first deserialiser, show-ahead
// receive FIFO, and sticky framing-error / overrun flags.
`timescale 1ns/1ps
module uart_rx #(
   parameter int CLOCK_FREQ = 10_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          CLK,
   input  logic                          RSTb,
   input  logic                          rx,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_rd,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr
);

   localparam int BAUD_DIV = CLOCK_FREQ / BAUD;
   localparam int CW       = $clog2(BAUD_DIV);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
   localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t          state, state_next;
   logic            rx_m, rx_s, rx_prev;
   logic [1:0]      sync_fill;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            baud_done, fall, full, pop;
   logic            push, drop, frame_bad;

   // rx_prev stays low until the synchroniser holds real pin samples, so the
   // forced-high reset values can never fake a start edge on a low line.
   // NOTE: every clocked assignment uses <= so all flops update from pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         rx_m      <= 1'b1;
         rx_s      <= 1'b1;
         rx_prev   <= 1'b0;
         sync_fill <= 2'b00;
      end else begin
         rx_m      <= rx;
         rx_s      <= rx_m;
         sync_fill <= {sync_fill[0], 1'b1};
         rx_prev   <= sync_fill[1] ? rx_s : 1'b0;
      end
   end

   assign baud_done = (baud_cnt == '0);
   assign fall      = rx_prev & ~rx_s;
   assign rx_valid  = (fifo_count != '0);
   assign full      = (fifo_count == DEPTH_L);
   assign pop       = rx_rd & rx_valid;
   assign rx_data   = rx_valid ? mem[rd_ptr] : 8'h00;

   // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
   always_comb begin
      state_next = state;
      push       = 1'b0;
      drop       = 1'b0;
      frame_bad  = 1'b0;
      case (state)
         IDLE:  if (fall) state_next = START;
         START: if (baud_done) state_next = rx_s ? IDLE : DATA;
         DATA:  if (baud_done && bit_cnt == 3'd7) state_next = STOP;
         STOP: begin
            if (baud_done) begin
               if (rx_s) begin
                  state_next = IDLE;
                  if (!full || pop) push = 1'b1;
                  else              drop = 1'b1;
               end else begin
                  state_next = BREAK;
                  frame_bad  = 1'b1;
               end
            end
         end
         BREAK: if (rx_s) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (fall) baud_cnt <= HALF_LOAD;
            START, DATA, STOP: begin
               baud_cnt <= baud_done ? FULL_LOAD : baud_cnt - 1'b1;
               if (state == DATA && baud_done) begin
                  shift   <= {rx_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the storage array is not reset; rx_valid gates every read of it.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= shift;
   end

   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
      end
   end

   // err_clr wins over a same-cycle set.
   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else if (err_clr) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (frame_bad) frame_err <= 1'b1;
         if (drop)      overrun   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: a 115200-baud line driver with hand-computed
// expected bytes, FIFO contents, flag states and stop-sample timing.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int BIT_NS = 8680;

   logic       CLK, RSTb, rx, rx_rd, err_clr;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun;
   logic [4:0] fifo_count;

   int vectors     = 0;
   int miscompares = 0;
   logic [7:0] burst_bytes [4];

   uart_rx dut (
      .CLK        (CLK),
      .RSTb       (RSTb),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_rd      (rx_rd),
      .fifo_count (fifo_count),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .err_clr    (err_clr)
   );

   initial CLK = 1'b0;
   always #50 CLK = ~CLK;

   // Line edges land 25 ns after a clock edge, then drift in 20 ns steps; never on an edge.
   task automatic align();
      @(posedge CLK);
      #25;
   endtask

   // Leaves the line at the stop-bit level.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(BIT_NS);
      end
      rx = stop_bit;
      #(BIT_NS);
   endtask

   task automatic idle_bits(input int n);
      #(n * BIT_NS);
   endtask

   task automatic pop_one();
      @(negedge CLK);
      rx_rd = 1'b1;
      @(negedge CLK);
      rx_rd = 1'b0;
   endtask

   task automatic pulse_err_clr();
      @(negedge CLK);
      err_clr = 1'b1;
      @(negedge CLK);
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      RSTb = 1'b0; rx = 1'b1; rx_rd = 1'b0; err_clr = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      vectors++;
      if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
      vectors++;
      if (fifo_count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      vectors++;
      if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", rx_data); end
      vectors++;
      if ({frame_err, overrun} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {frame_err, overrun}); end
      RSTb = 1'b1;
      repeat (10) @(posedge CLK);
   endtask

   // Start edge reaches rx_m at E1; the stop bit is sampled at E1+819.
   task automatic test_single_byte();
      align();
      fork
         send_byte(8'h55, 1'b1);
         begin
            @(posedge CLK);
            repeat (818) @(posedge CLK);
            @(negedge CLK);
            vectors++;
            if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL single_pre_sample: got %b want 0", rx_valid); end
            @(negedge CLK);
            vectors++;
            if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL single_rise: got %b want 1", rx_valid); end
         end
      join
      @(negedge CLK);
      vectors++;
      if (rx_data !== 8'h55) begin miscompares++; $display("FAIL single_data: got %h want 55", rx_data); end
      vectors++;
      if (fifo_count !== 5'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", fifo_count); end
      pop_one();
      @(negedge CLK);
      vectors++;
      if ({rx_valid, fifo_count} !== 6'd0) begin miscompares++; $display("FAIL single_pop: got valid=%b count=%0d want 0/0", rx_valid, fifo_count); end
   endtask

   task automatic test_back_to_back();
      burst_bytes = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
      align();
      for (int i = 0; i < 4; i++) send_byte(burst_bytes[i], 1'b1);
      idle_bits(1);
      @(negedge CLK);
      vectors++;
      if (fifo_count !== 5'd4) begin miscompares++; $display("FAIL burst_count: got %0d want 4", fifo_count); end
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         vectors++;
         if (rx_data !== burst_bytes[i]) begin miscompares++; $display("FAIL burst_byte%0d: got %h want %h", i, rx_data, burst_bytes[i]); end
         pop_one();
      end
      @(negedge CLK);
      vectors++;
      if ({frame_err, overrun, rx_valid} !== 3'b000) begin miscompares++; $display("FAIL burst_flags: got fe/ov/valid=%b want 000", {frame_err, overrun, rx_valid}); end
   endtask

   task automatic test_overrun();
      align();
      for (int b = 1; b <= 17; b++) send_byte(8'(b), 1'b1);
      idle_bits(1);
      @(negedge CLK);
      vectors++;
      if (fifo_count !== 5'd16) begin miscompares++; $display("FAIL ovr_count: got %0d want 16", fifo_count); end
      vectors++;
      if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b want 1", overrun); end
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         vectors++;
         if (rx_data !== 8'(i + 1)) begin miscompares++; $display("FAIL ovr_pop%0d: got %h want %h", i, rx_data, 8'(i + 1)); end
         pop_one();
      end
      pulse_err_clr();
      @(negedge CLK);
      vectors++;
      if ({overrun, fifo_count} !== 6'd0) begin miscompares++; $display("FAIL ovr_clear: got ov=%b count=%0d want 0/0", overrun, fifo_count); end

      // Pop on the very cycle the 17th stop bit is sampled.
      align();
      for (int b = 1; b <= 16; b++) send_byte(8'(b), 1'b1);
      fork
         send_byte(8'h11, 1'b1);
         begin
            @(posedge CLK);
            repeat (818) @(posedge CLK);
            #10 rx_rd = 1'b1;
            @(posedge CLK);
            #10 rx_rd = 1'b0;
         end
      join
      idle_bits(1);
      @(negedge CLK);
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_rd_flag: got %b want 0", overrun); end
      vectors++;
      if (fifo_count !== 5'd16) begin miscompares++; $display("FAIL ovr_rd_count: got %0d want 16", fifo_count); end
      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         vectors++;
         if (rx_data !== 8'(i + 2)) begin miscompares++; $display("FAIL ovr_rd_pop%0d: got %h want %h", i, rx_data, 8'(i + 2)); end
         pop_one();
      end
   endtask

   task automatic test_framing_break();
      align();
      send_byte(8'h81, 1'b0);
      idle_bits(30);
      @(negedge CLK);
      vectors++;
      if (frame_err !== 1'b1) begin miscompares++; $display("FAIL frame_set: got %b want 1", frame_err); end
      vectors++;
      if (fifo_count !== 5'd0) begin miscompares++; $display("FAIL frame_nopush: got %0d want 0", fifo_count); end
      rx = 1'b1;
      idle_bits(2);
      align();
      send_byte(8'h42, 1'b1);
      idle_bits(1);
      @(negedge CLK);
      vectors++;
      if ({fifo_count, rx_data} !== {5'd1, 8'h42}) begin miscompares++; $display("FAIL frame_next_byte: got count=%0d data=%h want 1/42", fifo_count, rx_data); end
      vectors++;
      if (frame_err !== 1'b1) begin miscompares++; $display("FAIL frame_sticky: got %b want 1", frame_err); end
      pop_one();
      pulse_err_clr();
      @(negedge CLK);
      vectors++;
      if (frame_err !== 1'b0) begin miscompares++; $display("FAIL frame_clear: got %b want 0", frame_err); end
   endtask

   task automatic test_glitch();
      align();
      rx = 1'b0;
      #1000;
      rx = 1'b1;
      idle_bits(2);
      @(negedge CLK);
      vectors++;
      if ({rx_valid, frame_err, overrun} !== 3'b000) begin miscompares++; $display("FAIL glitch_quiet: got valid/fe/ov=%b want 000", {rx_valid, frame_err, overrun}); end
      align();
      send_byte(8'h7E, 1'b1);
      idle_bits(1);
      @(negedge CLK);
      vectors++;
      if ({fifo_count, rx_data} !== {5'd1, 8'h7E}) begin miscompares++; $display("FAIL glitch_next_byte: got count=%0d data=%h want 1/7e", fifo_count, rx_data); end
   endtask

   // 0x7E from the glitch test is still queued, so the reset has state to clear.
   task automatic test_reset_mid_frame();
      align();
      fork
         send_byte(8'hC3, 1'b1);
         begin
            #(BIT_NS * 11 / 2);
            @(negedge CLK);
            RSTb = 1'b0;
            @(negedge CLK);
            vectors++;
            if ({rx_valid, fifo_count, rx_data, frame_err, overrun} !== 16'd0) begin
               miscompares++;
               $display("FAIL midrst_outputs: got valid=%b count=%0d data=%h fe=%b ov=%b want all 0",
                        rx_valid, fifo_count, rx_data, frame_err, overrun);
            end
            RSTb = 1'b1;
         end
      join
      idle_bits(2);
      align();
      send_byte(8'h99, 1'b1);
      idle_bits(1);
      @(negedge CLK);
      vectors++;
      if ({fifo_count, rx_data} !== {5'd1, 8'h99}) begin miscompares++; $display("FAIL midrst_next_byte: got count=%0d data=%h want 1/99", fifo_count, rx_data); end
      vectors++;
      if ({frame_err, overrun} !== 2'b00) begin miscompares++; $display("FAIL midrst_flags: got %b want 00", {frame_err, overrun}); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overrun();
      test_framing_break();
      test_glitch();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
